// File: rtl/apb_pkg.sv
// Shared APB definitions for the completer and requester ends of the bus.
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 8;
   localparam int unsigned APB_DATA_W = 8;

   typedef enum logic {
      StIdle   = 1'b0,
      StAccess = 1'b1
   } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// Register storage for the APB completer: synchronous write, combinational read.
module apb_regfile
   import apb_pkg::*;
#(
   parameter int unsigned DATA_W = APB_DATA_W,
   parameter int unsigned NREGS  = 16,
   parameter int unsigned IDX_W  = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] mem_q [NREGS];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   // Out-of-range indices are masked by the caller's decode.
   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/apb_slave.sv
// APB completer: decodes setup/enable transfers into a small register file with
// configurable wait states, error responses and a sticky protocol-violation flag.
module apb_slave
   import apb_pkg::*;
#(
   parameter int unsigned        ADDR_W      = APB_ADDR_W,
   parameter int unsigned        DATA_W      = APB_DATA_W,
   parameter int unsigned        NREGS       = 16,
   parameter int unsigned        WAIT_STATES = 0,
   parameter logic [DATA_W-1:0]  ID_VALUE    = DATA_W'(8'hA5)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_paddr,
   input  logic              i_psel,
   input  logic              i_penable,
   input  logic              i_pwrite,
   input  logic [DATA_W-1:0] i_pwdata,
   output logic              o_pready,
   output logic [DATA_W-1:0] o_prdata,
   output logic              o_pslverr,
   output logic              o_wr_pulse,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic              o_proto_err
);

   localparam int unsigned       IdxW   = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [ADDR_W:0]   NregsW = (ADDR_W + 1)'(NREGS);
   localparam logic [ADDR_W-1:0] IdAddr = ADDR_W'(NREGS - 1);
   localparam logic [3:0]        WaitLd = 4'(WAIT_STATES);

   apb_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              pready_q, pready_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;
   logic              pslverr_q, pslverr_d;
   logic              wr_pulse_q, wr_pulse_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              proto_err_q, proto_err_d;

   logic              rf_we;
   logic [DATA_W-1:0] rf_rdata;
   logic              in_range;
   logic              is_id;
   logic              dec_err;
   logic [DATA_W-1:0] dec_rdata;

   apb_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .IDX_W  (IdxW)
   ) u_regfile (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_we    (rf_we),
      .i_waddr (i_paddr[IdxW-1:0]),
      .i_wdata (i_pwdata),
      .i_raddr (i_paddr[IdxW-1:0]),
      .o_rdata (rf_rdata)
   );

   // Response decode for the address currently on the bus.
   always_comb begin
      in_range  = ({1'b0, i_paddr} < NregsW);
      is_id     = (i_paddr == IdAddr);
      dec_err   = !in_range || (is_id && i_pwrite);
      dec_rdata = '0;
      if (!i_pwrite && !dec_err) begin
         dec_rdata = is_id ? ID_VALUE : rf_rdata;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pready_d    = 1'b0;
      prdata_d    = '0;
      pslverr_d   = 1'b0;
      wr_pulse_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      proto_err_d = proto_err_q;
      rf_we       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_psel && !i_penable) begin
               cnt_d    = WaitLd;
               pready_d = (WAIT_STATES == 0);
               state_d  = StAccess;
               if (pready_d) begin
                  prdata_d  = dec_rdata;
                  pslverr_d = dec_err;
               end
            end else if (i_penable) begin
               proto_err_d = 1'b1;
            end
         end
         StAccess: begin
            if (!i_psel) begin
               proto_err_d = 1'b1;
               state_d     = StIdle;
            end else if (!i_penable) begin
               // A fresh setup mid-transfer restarts the access.
               proto_err_d = 1'b1;
               cnt_d       = WaitLd;
               pready_d    = (WAIT_STATES == 0);
               if (pready_d) begin
                  prdata_d  = dec_rdata;
                  pslverr_d = dec_err;
               end
            end else if (!pready_q) begin
               cnt_d    = cnt_q - 4'd1;
               pready_d = (cnt_q == 4'd1);
               if (pready_d) begin
                  prdata_d  = dec_rdata;
                  pslverr_d = dec_err;
               end
            end else begin
               rf_we      = i_pwrite && !pslverr_q;
               wr_pulse_d = rf_we;
               if (rf_we) begin
                  wr_addr_d = i_paddr;
               end
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         pready_q    <= 1'b0;
         prdata_q    <= '0;
         pslverr_q   <= 1'b0;
         wr_pulse_q  <= 1'b0;
         wr_addr_q   <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pready_q    <= pready_d;
         prdata_q    <= prdata_d;
         pslverr_q   <= pslverr_d;
         wr_pulse_q  <= wr_pulse_d;
         wr_addr_q   <= wr_addr_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign o_pready    = pready_q;
   assign o_prdata    = prdata_q;
   assign o_pslverr   = pslverr_q;
   assign o_wr_pulse  = wr_pulse_q;
   assign o_wr_addr   = wr_addr_q;
   assign o_proto_err = proto_err_q;

endmodule
